// File: rtl/nib_track_sync.sv
// ============================================================================
// Module   : nib_track_sync
// Purpose  : One-track NIB cache between the hps_io SD block port and the
//            Disk II track RAM. Optional write-back enabled by NIB_WRITEBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nib_track_sync #(
    parameter int SECTORS = 13
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [5:0]  track,
    input  logic        img_mounted,
    input  logic        img_present,
    input  logic        trk_we,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic        cpu_wait,
    output logic        dirty
);

    localparam logic [31:0] C_SECTORS_32 = 32'(SECTORS);
    localparam logic [3:0]  C_SECTORS_4  = 4'(SECTORS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB_REQ  = 3'd1,
        S_WB_XFER = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_XFER = 3'd4
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cur_track;
    logic [3:0]  r_sec;
    logic        r_mount_pend;
    logic        r_ack_d;
    logic [31:0] r_lba;
    logic        r_rd;
    logic        r_wait;

    logic        w_ack_rise;
    logic        w_ack_fall;
    logic        w_pend;
    logic        w_new_track;
    logic [3:0]  w_sec_inc;
    logic [31:0] w_lba_track;

    assign w_ack_rise  = sd_ack & ~r_ack_d;
    assign w_ack_fall  = ~sd_ack & r_ack_d;
    // A mount pulse arriving in the same cycle counts as already pending.
    assign w_pend      = r_mount_pend | img_mounted;
    assign w_new_track = (track != r_cur_track) || w_pend;
    assign w_sec_inc   = r_sec + 4'd1;
    assign w_lba_track = {26'd0, track} * C_SECTORS_32;

`ifdef NIB_WRITEBACK_EN
    logic        r_dirty;
    logic        r_wr;
    logic [31:0] w_lba_cur;

    assign w_lba_cur   = {26'd0, r_cur_track} * C_SECTORS_32;
    assign sd_wr       = r_wr;
    assign dirty       = r_dirty;
    assign sd_buff_din = (r_state == S_WB_REQ || r_state == S_WB_XFER) ? ram_dout : 8'd0;
`else
    logic w_unused_ro;

    assign w_unused_ro = &{1'b0, trk_we, ram_dout};
    assign sd_wr       = 1'b0;
    assign dirty       = 1'b0;
    assign sd_buff_din = 8'd0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cur_track  <= 6'h3F;
            r_sec        <= 4'd0;
            r_mount_pend <= 1'b0;
            r_ack_d      <= 1'b0;
            r_lba        <= 32'd0;
            r_rd         <= 1'b0;
            r_wait       <= 1'b0;
`ifdef NIB_WRITEBACK_EN
            r_dirty      <= 1'b0;
            r_wr         <= 1'b0;
`endif
        end else begin
            r_ack_d <= sd_ack;
            if (img_mounted) begin
                r_mount_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_wait <= 1'b0;
                    if (!img_present) begin
                        r_cur_track  <= track;
                        r_mount_pend <= 1'b0;
`ifdef NIB_WRITEBACK_EN
                        r_dirty      <= 1'b0;
`endif
                    end else if (w_new_track) begin
                        r_wait <= 1'b1;
                        r_sec  <= 4'd0;
`ifdef NIB_WRITEBACK_EN
                        // A fresh mount discards the old image's changes.
                        if (r_dirty && !w_pend) begin
                            r_lba   <= w_lba_cur;
                            r_wr    <= 1'b1;
                            r_state <= S_WB_REQ;
                        end else
`endif
                        begin
                            r_cur_track  <= track;
                            r_mount_pend <= 1'b0;
`ifdef NIB_WRITEBACK_EN
                            r_dirty      <= 1'b0;
`endif
                            r_lba        <= w_lba_track;
                            r_rd         <= 1'b1;
                            r_state      <= S_RD_REQ;
                        end
                    end
`ifdef NIB_WRITEBACK_EN
                    else if (trk_we) begin
                        r_dirty <= 1'b1;
                    end
`endif
                end

`ifdef NIB_WRITEBACK_EN
                S_WB_REQ: begin
                    if (w_ack_rise) begin
                        r_wr    <= 1'b0;
                        r_state <= S_WB_XFER;
                    end
                end

                S_WB_XFER: begin
                    if (w_ack_fall) begin
                        if (w_pend || w_sec_inc == C_SECTORS_4) begin
                            r_cur_track  <= track;
                            r_mount_pend <= 1'b0;
                            r_dirty      <= 1'b0;
                            r_sec        <= 4'd0;
                            r_lba        <= w_lba_track;
                            r_rd         <= 1'b1;
                            r_state      <= S_RD_REQ;
                        end else begin
                            r_sec   <= w_sec_inc;
                            r_lba   <= r_lba + 32'd1;
                            r_wr    <= 1'b1;
                            r_state <= S_WB_REQ;
                        end
                    end
                end
`endif

                S_RD_REQ: begin
                    if (w_ack_rise) begin
                        r_rd    <= 1'b0;
                        r_state <= S_RD_XFER;
                    end
                end

                S_RD_XFER: begin
                    if (w_ack_fall) begin
                        r_lba <= r_lba + 32'd1;
                        if (w_sec_inc == C_SECTORS_4) begin
                            r_sec   <= 4'd0;
                            r_wait  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_sec   <= w_sec_inc;
                            r_rd    <= 1'b1;
                            r_state <= S_RD_REQ;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sd_lba   = r_lba;
    assign sd_rd    = r_rd;
    assign cpu_wait = r_wait;
    assign ram_addr = {r_sec, sd_buff_addr};
    assign ram_din  = sd_buff_dout;
    assign ram_we   = (r_state == S_RD_XFER) & sd_buff_wr;

endmodule

`default_nettype wire

// File: doc/nib_track_sync.md
# nib_track_sync

Track-cache controller between the `hps_io` SD block interface and the 6656-byte Disk II track RAM. It keeps exactly one NIB track resident. On a head track change or image mount, it writes the dirty resident track back to the image, then loads the requested track as 13 × 512-byte sectors. While a transfer runs, it stalls the CPU through `cpu_wait`.

## Interface
- `SECTORS`, 13: 512-byte sectors per track; sector LBA = `SECTORS*track + sec`.
- `clk_sys  in  1`: system clock (14 MHz domain); all logic on rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `track  in  6`: track currently under the head (from drive logic).
- `img_mounted  in  1`: one-cycle pulse on image (re)mount.
- `img_present  in  1`: image size non-zero.
- `trk_we  in  1`: drive wrote a nibble into track RAM; marks the track dirty.
- `sd_lba  out  32`: sector LBA.
- `sd_rd  out  1`: read request.
- `sd_wr  out  1`: write request.
- `sd_ack  in  1`: `hps_io` transfer acknowledge.
- `sd_buff_addr  in  9`: byte index within the sector.
- `sd_buff_dout  in  8`: read data.
- `sd_buff_wr  in  1`: read-data strobe.
- `sd_buff_din  out  8`: write data to `hps_io`.
- `ram_addr  out  13`: track RAM address, `{sec[3:0], sd_buff_addr}`.
- `ram_din  out  8`, `ram_we  out  1`: track RAM write port.
- `ram_dout  in  8`: track RAM read data, 1-cycle latency.
- `cpu_wait  out  1`: CPU stall.
- `dirty  out  1`: resident track modified.

## Operation
- Registers:
  - `cur_track`: resets to 6'h3F, so the first valid track always mismatches.
  - `sec` (4 b).
  - `dirty`.
  - `mount_pend`: set by `img_mounted` in any state.
- States:
  - IDLE:
    - `cpu_wait`=0.
    - If `img_present` and (`track`≠`cur_track` or `mount_pend`):
      - `cpu_wait`←1 and `sec`←0.
      - If `dirty` and not `mount_pend`, go to WB_REQ with `sd_lba`←`SECTORS*cur_track`.
      - Otherwise `cur_track`←`track`, `mount_pend`←0, `dirty`←0, `sd_lba`←`SECTORS*track`, go to RD_REQ.
    - If `img_present`=0: `cur_track`←`track`, `dirty`←0, `mount_pend`←0; no SD traffic.
  - WB_REQ: `sd_wr`=1 until `sd_ack` rises, then go to WB_XFER.
  - WB_XFER: on `sd_ack` fall, `sec`++ and `sd_lba`++.
    - `sec` reaches `SECTORS`: `dirty`←0, `sec`←0, `cur_track`←`track`, `sd_lba`←`SECTORS*track`, go to RD_REQ.
    - Otherwise return to WB_REQ.
    - If `mount_pend` is set at the fall: skip the remaining sectors and go to RD_REQ for `track`, with `cur_track`←`track`, `mount_pend`←0, `dirty`←0, `sec`←0.
  - RD_REQ: `sd_rd`=1 until `sd_ack` rises, then go to RD_XFER.
  - RD_XFER: on `sd_ack` fall, `sec`++ and `sd_lba`++.
    - `sec` reaches `SECTORS`: go to IDLE.
    - Otherwise return to RD_REQ.
- Track RAM mux:
  - `ram_addr`={`sec`,`sd_buff_addr`} in all states.
  - In RD_XFER: `ram_we`=`sd_buff_wr`, `ram_din`=`sd_buff_dout`. Otherwise `ram_we`=0.
  - In WB states: `sd_buff_din`=`ram_dout`.
- Edge detection: `sd_ack` edges use a registered copy. Edges are counted only in the matching REQ/XFER state.
- Arithmetic:
  - LBA multiply is 6 b × constant, zero-extended to 32 b.
  - `sec` compare is on 4 b; `SECTORS` ≤ 15.
- `trk_we` sets `dirty` only in IDLE. It is ignored while busy, because the CPU is stalled.
- Track change mid-transfer: not sampled until IDLE. The next IDLE cycle re-evaluates and starts a new load if `track`≠`cur_track`.
- Mount mid-read: the current read sequence completes; `mount_pend` then forces a reload from IDLE. There is no write-back into the new image.

## Timing
- Reset (async assert, sync deassert by the top level) values:
  - State IDLE.
  - All outputs 0, except `cur_track`=3F.
  - `sd_lba`=0, `sec`=0, `dirty`=0, `mount_pend`=0.
- IDLE → REQ: 1 cycle after the condition. `cpu_wait`, `sd_rd`/`sd_wr` and `sd_lba` all change on the same edge.
- A request drops on the cycle after the `sd_ack` rising edge is registered. It is never high while `sd_ack`=1 within the same sector.
- `sd_buff_din` lags `sd_buff_addr` by 1 cycle; `hps_io` samples ≥2 cycles after an address change.
- `cpu_wait` falls on the edge entering IDLE after the last read sector's `sd_ack` fall.
- Total stall time is governed by `hps_io` latency: 13 (clean) or 26 (dirty) sector handshakes plus 1 cycle.

## Configuration
- `NIB_WRITEBACK_EN` defined:
  - Dirty tracking and WB_REQ/WB_XFER are compiled in.
- `NIB_WRITEBACK_EN` undefined:
  - `dirty` is tied 0 and the WB states are absent.
  - `sd_wr` and `sd_buff_din` are tied 0.
  - The block is a read-only loader.

## Test plan
- Reset, `img_present`=1, `track`=0:
  - → `sd_rd` for LBA 0..12 in order, 13 handshakes.
  - 6656 `ram_we` strobes to addresses 0..0x19FF.
  - `cpu_wait` high throughout, then 0.
- Track 0 resident, `track`→5, clean:
  - → reads LBA 65..77.
  - `sd_wr` never asserted.
- Track 5 resident, one `trk_we`, `track`→6:
  - → writes LBA 65..77, with `sd_buff_din` matching RAM contents.
  - Then reads LBA 78..90.
  - `dirty`=0 at end.
- `img_mounted` pulse during WB_XFER of sector 3:
  - → no `sd_wr` after sector 3 completes.
  - Reload of the current `track` from LBA `13*track`.
- `track` changes 5→6→7 during a read of track 6:
  - → read of track 6 completes.
  - `cpu_wait` stays 0 for exactly 1 cycle (the IDLE pass), then a read of LBA 91..103.
- `reset_n` low mid-RD_XFER:
  - → `sd_rd`, `cpu_wait`, `ram_we` all 0 immediately.
  - After release, a full reload of `track`.
